// File: rtl/beam_wr_ctrl.sv
// Write-side framing controller for the four-block beam buffer. It assigns
// per-block write addresses and tracks the block index, overflow and framing errors.
//
// state | meaning
// IDLE  | ready for i_sof, o_rdy high
// WRITE | inside a block, writing samples at the running address
// GAP   | block closed, inputs ignored while the inter-block gap elapses
module beam_wr_ctrl #(
  parameter int WDATA_WIDTH = 40,
  parameter int WADDR_WIDTH = 11,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_vld,
  input  logic                        i_sof,
  input  logic                        i_eof,
  input  logic [16*WDATA_WIDTH-1:0]   i_data,
  output logic                        o_rdy,
  output logic                        o_rvalid,
  output logic                        o_wr_wen,
  output logic [WADDR_WIDTH-1:0]      o_wr_addr,
  output logic [16*WDATA_WIDTH-1:0]   o_wr_data,
  output logic [1:0]                  o_blk_idx,
  output logic [WADDR_WIDTH:0]        o_blk_len,
  output logic                        o_frame_done,
  output logic                        o_err_ovf,
  output logic                        o_err_sof
);

  localparam int DW = 16 * WDATA_WIDTH;
  localparam logic [WADDR_WIDTH:0] CAP    = {1'b1, {WADDR_WIDTH{1'b0}}};
  localparam logic [WADDR_WIDTH:0] ONE    = (WADDR_WIDTH+1)'(1);
  localparam logic [3:0]           GAP_LD = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t                 state_q, state_d;
  logic [WADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [3:0]             gap_q, gap_d;
  logic                   rdy_q, rdy_d;
  logic                   rvalid_q, rvalid_d;
  logic                   wen_q, wen_d;
  logic [WADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]          data_q, data_d;
  logic [1:0]             idx_q, idx_d;
  logic [WADDR_WIDTH:0]   len_q, len_d;
  logic                   fdone_q, fdone_d;
  logic                   ovf_q, ovf_d;
  logic                   esof_q, esof_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    rvalid_d = 1'b0;
    wen_d    = 1'b0;
    addr_d   = addr_q;
    idx_d    = idx_q;
    len_d    = len_q;
    fdone_d  = 1'b0;
    ovf_d    = ovf_q;
    esof_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // rdy_q gates acceptance so o_rdy is exact in the first cycle after reset
        if (rdy_q && i_vld && i_sof) begin
          wen_d    = 1'b1;
          addr_d   = '0;
          cnt_d    = ONE;
          rvalid_d = 1'b1;
          if (i_eof) begin
            len_d   = ONE;
            state_d = GAP;
            gap_d   = GAP_LD;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        rvalid_d = 1'b1;
        if (i_vld) begin
          if (i_sof) begin
            esof_d = 1'b1;
            wen_d  = 1'b1;
            addr_d = '0;
            cnt_d  = ONE;
            if (i_eof) len_d = ONE;
          end else if (cnt_q == CAP) begin
            ovf_d = 1'b1;
            if (i_eof) len_d = CAP;
          end else begin
            wen_d  = 1'b1;
            addr_d = cnt_q[WADDR_WIDTH-1:0];
            cnt_d  = cnt_q + ONE;
            if (i_eof) len_d = cnt_q + ONE;
          end
          if (i_eof) begin
            state_d = GAP;
            gap_d   = GAP_LD;
          end
        end
      end
      GAP: begin
        if (gap_q == 4'd0) begin
          state_d = IDLE;
          idx_d   = idx_q + 2'd1;
          fdone_d = (idx_q == 2'd3);
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d  = (state_d == IDLE);
    data_d = wen_d ? i_data : data_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      rdy_q    <= 1'b0;
      rvalid_q <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      fdone_q  <= 1'b0;
      ovf_q    <= 1'b0;
      esof_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      rdy_q    <= rdy_d;
      rvalid_q <= rvalid_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      fdone_q  <= fdone_d;
      ovf_q    <= ovf_d;
      esof_q   <= esof_d;
    end
  end

  assign o_rdy        = rdy_q;
  assign o_rvalid     = rvalid_q;
  assign o_wr_wen     = wen_q;
  assign o_wr_addr    = addr_q;
  assign o_wr_data    = data_q;
  assign o_blk_idx    = idx_q;
  assign o_blk_len    = len_q;
  assign o_frame_done = fdone_q;
  assign o_err_ovf    = ovf_q;
  assign o_err_sof    = esof_q;

endmodule

// File: tb/tb_beam_wr_ctrl.sv
// Randomized bench for beam_wr_ctrl: a full-size instance and a 3-bit-address
// instance share stimulus and are scored against a block-level write model.
module tb_beam_wr_ctrl;

  localparam int DW   = 640;
  localparam int GAP  = 2;
  localparam int CAP0 = 2048;
  localparam int CAP1 = 8;

  typedef struct packed {
    logic [10:0]   addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk, rst_n, vld, sof, eof;
  logic [DW-1:0] data;

  logic          b_rdy, b_rvalid, b_wen, b_fdone, b_ovf, b_esof;
  logic [10:0]   b_addr;
  logic [DW-1:0] b_data;
  logic [1:0]    b_idx;
  logic [11:0]   b_len;

  logic          s_rdy, s_rvalid, s_wen, s_fdone, s_ovf, s_esof;
  logic [2:0]    s_addr;
  logic [DW-1:0] s_data;
  logic [1:0]    s_idx;
  logic [3:0]    s_len;

  beam_wr_ctrl #(.WDATA_WIDTH(40), .WADDR_WIDTH(11), .GAP_CYCLES(GAP)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .i_sof(sof), .i_eof(eof), .i_data(data),
    .o_rdy(b_rdy), .o_rvalid(b_rvalid), .o_wr_wen(b_wen), .o_wr_addr(b_addr),
    .o_wr_data(b_data), .o_blk_idx(b_idx), .o_blk_len(b_len), .o_frame_done(b_fdone),
    .o_err_ovf(b_ovf), .o_err_sof(b_esof));

  beam_wr_ctrl #(.WDATA_WIDTH(40), .WADDR_WIDTH(3), .GAP_CYCLES(GAP)) u_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .i_sof(sof), .i_eof(eof), .i_data(data),
    .o_rdy(s_rdy), .o_rvalid(s_rvalid), .o_wr_wen(s_wen), .o_wr_addr(s_addr),
    .o_wr_data(s_data), .o_blk_idx(s_idx), .o_blk_len(s_len), .o_frame_done(s_fdone),
    .o_err_ovf(s_ovf), .o_err_sof(s_esof));

  int  n_chk = 0;
  int  n_fail = 0;
  wr_t exp_q0[$], exp_q1[$], act_q0[$], act_q1[$];
  int  m_blocks = 0;
  bit  m_ovf0 = 0, m_ovf1 = 0;
  int  rv_hi = 0, fd_cnt = 0, esof_cnt = 0, cyc = 0, t_fall = 0, t_rise = 0;
  logic rv_prev = 0, rdy_prev = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int k = 0; k < 20; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(negedge clk) begin
    wr_t w;
    if (rst_n) begin
      cyc++;
      if (b_wen) begin
        w.addr = b_addr; w.data = b_data; act_q0.push_back(w);
      end
      if (s_wen) begin
        w.addr = {8'b0, s_addr}; w.data = s_data; act_q1.push_back(w);
      end
      if (b_rvalid) rv_hi++;
      if (b_fdone) fd_cnt++;
      if (b_esof) esof_cnt++;
      if (rv_prev && !b_rvalid) t_fall = cyc;
      if (!rdy_prev && b_rdy) t_rise = cyc;
    end
    rv_prev  = b_rvalid;
    rdy_prev = b_rdy;
  end

  // Inputs are junk while waiting; the DUT must ignore them in GAP.
  task automatic wait_rdy();
    int n = 0;
    while (b_rdy !== 1'b1 && n < 200) begin
      vld = 1'($urandom_range(0, 1)); sof = 0; eof = 1'($urandom_range(0, 1));
      data = rnd_data();
      @(negedge clk);
      n++;
    end
    chk("rdy_wait", b_rdy, 1);
    vld = 0; sof = 0; eof = 0;
  endtask

  task automatic cmp_queues();
    chk("wr_count_big", act_q0.size(), exp_q0.size());
    chk("wr_count_small", act_q1.size(), exp_q1.size());
    for (int i = 0; i < act_q0.size() && i < exp_q0.size(); i++) begin
      chk("wr_addr_big", act_q0[i].addr, exp_q0[i].addr);
      chk("wr_data_big", act_q0[i].data, exp_q0[i].data);
    end
    for (int i = 0; i < act_q1.size() && i < exp_q1.size(); i++) begin
      chk("wr_addr_small", act_q1[i].addr, exp_q1[i].addr);
      chk("wr_data_small", act_q1[i].data, exp_q1[i].data);
    end
    act_q0.delete(); act_q1.delete(); exp_q0.delete(); exp_q1.delete();
  endtask

  // resof: sample index that re-asserts i_sof inside the block, -1 for none
  task automatic send_block(input int len, input int resof, input int max_hole);
    int holes, j0, j1, nsof, esof0;
    logic [DW-1:0] d;
    wait_rdy();
    repeat ($urandom_range(0, 2)) begin
      vld = 1; sof = 0; eof = 1'($urandom_range(0, 1)); data = rnd_data();
      @(negedge clk);
    end
    rv_hi = 0; esof0 = esof_cnt; holes = 0; j0 = 0; j1 = 0; nsof = 0;
    for (int i = 0; i < len; i++) begin
      int h;
      h = (i > 0 && max_hole > 0) ? $urandom_range(0, max_hole) : 0;
      repeat (h) begin
        vld = 0; sof = 0; eof = 0;
        @(negedge clk);
        holes++;
      end
      d = rnd_data();
      vld = 1; sof = (i == 0) || (i == resof); eof = (i == len - 1); data = d;
      if (sof) begin
        j0 = 0; j1 = 0;
        if (i != 0) nsof++;
      end
      if (j0 < CAP0) begin
        exp_q0.push_back('{addr: 11'(j0), data: d}); j0++;
      end else m_ovf0 = 1;
      if (j1 < CAP1) begin
        exp_q1.push_back('{addr: 11'(j1), data: d}); j1++;
      end else m_ovf1 = 1;
      @(negedge clk);
      if (i == 0) begin
        #1;
        chk("start_rvalid", b_rvalid, 1);
        chk("start_addr", b_addr, 0);
        chk("start_idx", b_idx, m_blocks % 4);
      end
    end
    vld = 0; sof = 0; eof = 0;
    m_blocks++;
    wait_rdy();
    #1;
    chk("blk_len_big", b_len, j0);
    chk("blk_len_small", s_len, j1);
    chk("rvalid_cycles", rv_hi, len + holes);
    chk("gap_to_rdy", t_rise - t_fall, GAP);
    chk("blk_idx_big", b_idx, m_blocks % 4);
    chk("blk_idx_small", s_idx, m_blocks % 4);
    chk("frame_done_cnt", fd_cnt, m_blocks / 4);
    chk("err_sof_cnt", esof_cnt - esof0, nsof);
    chk("err_ovf_big", b_ovf, m_ovf0);
    chk("err_ovf_small", s_ovf, m_ovf1);
    cmp_queues();
  endtask

  task automatic reset_mid_block();
    wait_rdy();
    for (int i = 0; i < 3; i++) begin
      vld = 1; sof = (i == 0); eof = 0; data = rnd_data();
      @(negedge clk);
    end
    #2 rst_n = 0;
    #1;
    chk("rst_rdy", b_rdy, 0);
    chk("rst_rvalid", b_rvalid, 0);
    chk("rst_wen", b_wen, 0);
    chk("rst_addr", b_addr, 0);
    chk("rst_data", b_data, 0);
    chk("rst_idx", b_idx, 0);
    chk("rst_len", b_len, 0);
    chk("rst_ovf_small", s_ovf, 0);
    chk("rst_fdone", b_fdone, 0);
    chk("rst_esof", b_esof, 0);
    vld = 0; sof = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    act_q0.delete(); act_q1.delete(); exp_q0.delete(); exp_q1.delete();
    m_blocks = 0; m_ovf0 = 0; m_ovf1 = 0; fd_cnt = 0;
    send_block(5, -1, 0);
  endtask

  initial begin
    int len, rs;
    rst_n = 1; vld = 0; sof = 0; eof = 0; data = '0;
    #1 rst_n = 0;
    #6;
    chk("reset_rdy", b_rdy, 0);
    chk("reset_rvalid", b_rvalid, 0);
    chk("reset_len", b_len, 0);
    chk("reset_ovf", b_ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rdy_after_reset", b_rdy, 1);

    send_block(8, -1, 0);
    send_block(10, -1, 0);
    repeat (4) send_block(16, -1, 0);
    send_block(12, 4, 0);
    send_block(1, -1, 0);
    repeat (24) begin
      len = $urandom_range(1, 40);
      rs  = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
      send_block(len, rs, 2);
    end
    reset_mid_block();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/beam_wr_ctrl.md
# beam_wr_ctrl

Write-side framing controller placed directly upstream of the four-block beam buffer. It accepts a 16-channel sample stream delimited by start/end-of-block markers and assigns sequential write addresses per block. It produces the write-enable, write-address, write-data and the block-framing valid whose falling edge the beam buffer uses to advance its block index. It also tracks the block index (0..3), flags length and framing errors, and signals completion of each 4-block frame.

## Interface
- WDATA_WIDTH, 40, bits per channel sample
- WADDR_WIDTH, 11, write address width; max block length 2^WADDR_WIDTH samples
- GAP_CYCLES, 2, minimum cycles o_rvalid stays low between blocks (legal range 1..15)

- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_vld  in  1  input sample valid
- i_sof  in  1  first sample of a block; qualified by i_vld
- i_eof  in  1  last sample of a block; qualified by i_vld (may coincide with i_sof for 1-sample block)
- i_data  in  16×WDATA_WIDTH  channel samples
- o_rdy  out  1  high when a new i_sof can be accepted (IDLE state)
- o_rvalid  out  1  block framing, high for the whole accepted block
- o_wr_wen  out  1  write strobe to buffer
- o_wr_addr  out  WADDR_WIDTH  write address
- o_wr_data  out  16×WDATA_WIDTH  registered i_data
- o_blk_idx  out  2  index of the block currently / last written
- o_blk_len  out  WADDR_WIDTH+1  sample count of last completed block
- o_frame_done  out  1  one-cycle pulse after block 3 completes
- o_err_ovf  out  1  sticky: block exceeded 2^WADDR_WIDTH samples
- o_err_sof  out  1  one-cycle pulse: i_sof seen inside a block

## Operation
- States: IDLE, WRITE, GAP.
- IDLE: o_rdy=1. i_vld&i_sof → write sample at address 0, addr counter=1, go WRITE. If i_eof also set, go straight to GAP (1-sample block). i_vld without i_sof in IDLE is dropped silently.
- WRITE: each i_vld writes at addr counter, counter increments. i_vld&i_eof → write last sample, latch o_blk_len=counter+1, go GAP.
- Overflow: i_vld when counter = 2^WADDR_WIDTH (all addresses used) and not... any further sample is not written (o_wr_wen=0), o_err_ovf set sticky, o_blk_len saturates at 2^WADDR_WIDTH; block still terminates on i_eof.
- i_sof inside WRITE (not in IDLE): o_err_sof pulse; current block abandoned, counter restarts, that sample written at address 0; o_rvalid stays high, o_blk_idx unchanged.
- GAP: o_rvalid low, input ignored (o_rdy=0), count GAP_CYCLES then IDLE; o_blk_idx increments (mod 4) on GAP exit. If o_blk_idx was 3, o_frame_done pulses on GAP exit.
- o_err_ovf cleared only by reset.

## Timing
- All outputs registered; 1-cycle latency input→o_wr_wen/o_wr_addr/o_wr_data.
- o_rvalid rises the cycle after the accepted i_sof sample (same cycle as its o_wr_wen); falls the cycle after the i_eof sample, i.e. the cycle after the last o_wr_wen.
- o_rdy returns high GAP_CYCLES cycles after o_rvalid falls; minimum block-to-block spacing = len + GAP_CYCLES + 1 cycles.
- Reset values: o_rdy=0 during reset then 1 in IDLE; o_rvalid, o_wr_wen, o_frame_done, o_err_ovf, o_err_sof = 0; o_wr_addr, o_wr_data, o_blk_idx, o_blk_len = 0.
- Reset deassertion mid-block: FSM restarts in IDLE, block index 0; partially written block discarded (no o_rvalid falling edge emitted by this block during reset, since o_rvalid drops asynchronously — downstream must also be reset).
- Async reset asserted: all state clears immediately, independent of i_clk.

## Test plan
- Single block of 8 samples (sof at s0, eof at s7), gap-free i_vld → o_wr_addr 0..7, o_wr_wen 8 cycles, o_rvalid high 8 cycles, o_blk_len=8, o_blk_idx 0→1 after GAP_CYCLES=2.
- Four consecutive 16-sample blocks → o_blk_idx 0,1,2,3, o_rvalid has 4 falling edges each followed by ≥2 low cycles, o_frame_done single pulse after block 3, o_blk_idx wraps to 0.
- WADDR_WIDTH=3, 10-sample block → addresses 0..7 written, samples 9–10 not written, o_err_ovf=1 sticky, o_blk_len=8.
- i_sof re-asserted at 5th sample of block → o_err_sof pulse, that sample at addr 0, o_blk_idx unchanged, o_rvalid stays high.
- i_vld with i_sof&i_eof in IDLE → one write at addr 0, o_rvalid high exactly 1 cycle, o_blk_len=1.
- i_rst_n pulled low mid-block at sample 3 → all outputs 0 immediately; after release, new sof block writes from addr 0 with o_blk_idx=0.
